fft_input_loader: RTL and testbench



---
 rtl/fft_input_loader.sv | 85 ++++++++
 tb/tb_fft_input_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// fft_input_loader: streams N real samples into the FFT32 input register
// array (we/addr/data write port), then holds off input and flags a full
// frame until the FFT stage releases it.
// Optional macro FFT_LOADER_BITREV_EN: when defined, write addresses are
// bit-reversed; otherwise they follow natural sample order.
module fft_input_loader #(
  parameter int N   = 32,
  parameter int MSB = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [MSB-1:0]       in_data,
  output logic                 in_ready,
  output logic                 we,
  output logic [$clog2(N)-1:0] addr,
  output logic [MSB-1:0]       data,
  output logic                 frame_valid,
  input  logic                 frame_release,
  output logic [$clog2(N)-1:0] sample_cnt
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {LOAD, SETTLE, FULL} state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic [AW-1:0] cnt_rev;
  logic [AW-1:0] wr_addr;

  // in_ready is registered and tracks state==LOAD, so it gates accepts directly
  assign accept = in_valid && in_ready;

  // bit-reverse the natural-order count
  for (genvar i = 0; i < AW; i++) begin : g_rev
    assign cnt_rev[i] = sample_cnt[AW-1-i];
  end

`ifdef FFT_LOADER_BITREV_EN
  assign wr_addr = cnt_rev;
`else
  assign wr_addr = sample_cnt;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // next-state: last accept -> one settle cycle for the final write -> hold frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && sample_cnt == LAST) state_d = SETTLE;
      SETTLE:  state_d = FULL;
      FULL:    if (frame_release) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // registered write port, handshake and frame flag
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      we          <= 1'b0;
      addr        <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      sample_cnt  <= '0;
    end else begin
      we          <= accept;
      in_ready    <= (state_d == LOAD);
      frame_valid <= (state_d == FULL);
      if (accept) begin
        addr       <= wr_addr;
        data       <= in_data;
        sample_cnt <= sample_cnt + 1'b1;  // N is a power of two: wraps N-1 -> 0
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader (N=32, MSB=16).
module tb_fft_input_loader;
  logic        clk = 1'b0;
  logic        reset, in_valid, frame_release;
  logic [15:0] in_data;
  logic        in_ready, we, frame_valid;
  logic [4:0]  addr, sample_cnt;
  logic [15:0] data;

  int total = 0;
  int bad   = 0;

  fft_input_loader #(.N(32), .MSB(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .addr(addr), .data(data),
    .frame_valid(frame_valid), .frame_release(frame_release),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // expected write address for natural index i
  function automatic logic [4:0] ea(int i);
    logic [4:0] v;
    v = i[4:0];
`ifdef FFT_LOADER_BITREV_EN
    return {v[0], v[1], v[2], v[3], v[4]};
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; frame_release = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_sample_cnt", sample_cnt, 0);

    // full-rate frame, data = index
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = 16'(i);
      tick();
      chk("s1_we", we, 1);
      chk("s1_addr", addr, ea(i));
      chk("s1_data", data, i);
      chk("s1_cnt", sample_cnt, (i + 1) % 32);
      chk("s1_ready", in_ready, (i != 31));
      chk("s1_fv", frame_valid, 0);
    end
`ifdef FFT_LOADER_BITREV_EN
    chk("s1_last_addr", addr, 31);
`else
    chk("s1_last_addr", addr, 31);
`endif
    in_data = 16'h0099;
    tick();  // SETTLE -> FULL edge
    chk("s1_settle_we", we, 0);
    chk("s1_fv_rise", frame_valid, 1);
    chk("s1_full_ready", in_ready, 0);

    // hold in_valid in FULL
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("s2_we", we, 0);
      chk("s2_cnt", sample_cnt, 0);
      chk("s2_ready", in_ready, 0);
      chk("s2_fv", frame_valid, 1);
      chk("s2_data_hold", data, 31);
    end
    in_valid = 1'b0;
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    chk("s2_rel_ready", in_ready, 1);
    chk("s2_rel_fv", frame_valid, 0);
    chk("s2_rel_we", we, 0);
    in_valid = 1'b1; in_data = 16'hA5A5;
    tick();
    chk("s2_first_we", we, 1);
    chk("s2_first_addr", addr, 0);
    chk("s2_first_data", data, 16'hA5A5);
    chk("s2_first_cnt", sample_cnt, 1);
    in_valid = 1'b0; in_data = 16'h1234;
    tick();
    chk("s2_idle_we", we, 0);
    chk("s2_idle_addr", addr, 0);
    chk("s2_idle_data", data, 16'hA5A5);

    // reset mid-frame, then half-rate frame with an ignored release at sample 5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s3_rst_cnt", sample_cnt, 0);
    chk("s3_rst_ready", in_ready, 1);
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0100 + i);
      tick();
      chk("s3_we", we, 1);
      chk("s3_addr", addr, ea(i));
      chk("s3_data", data, 16'h0100 + i);
      chk("s3_cnt", sample_cnt, (i + 1) % 32);
      in_valid = 1'b0; in_data = 16'hFFFF;
      frame_release = (i == 5);
      tick();
      frame_release = 1'b0;
      chk("s3_idle_we", we, 0);
      chk("s3_idle_addr", addr, ea(i));
      chk("s3_idle_data", data, 16'h0100 + i);
      chk("s3_idle_cnt", sample_cnt, (i + 1) % 32);
      chk("s3_idle_ready", in_ready, (i != 31));
      chk("s3_idle_fv", frame_valid, (i == 31));
    end
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    chk("s3_rel_ready", in_ready, 1);

    // 13 accepts, then reset with in_valid still high
    in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_data = 16'(16'h0200 + i);
      tick();
      chk("s4_cnt", sample_cnt, i + 1);
    end
    reset = 1'b1; in_data = 16'h0BAD;
    tick();
    reset = 1'b0;
    chk("s4_rst_cnt", sample_cnt, 0);
    chk("s4_rst_we", we, 0);
    chk("s4_rst_ready", in_ready, 1);
    chk("s4_rst_fv", frame_valid, 0);
    for (int i = 0; i < 32; i++) begin
      in_data = 16'(16'h0300 + i);
      tick();
      chk("s4_we", we, 1);
      chk("s4_addr", addr, ea(i));
      chk("s4_data", data, 16'h0300 + i);
      chk("s4_fv", frame_valid, 0);
    end
    tick();
    chk("s4_fv_rise", frame_valid, 1);
    chk("s4_full_we", we, 0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
